// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: funct3 size codes, FSM encoding and the access legality rule.
package mem_access_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam int DMEM_BE_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } mem_state_t;

  // Used on both the incoming EX op (FSM entry) and the held EX/MEM op (error pulse).
  function automatic logic access_err(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3)
      MEM_B, MEM_BU: access_err = 1'b0;
      MEM_H, MEM_HU: access_err = addr[0];
      MEM_W:         access_err = |addr;
      default:       access_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory req/gnt/rvalid bus between the MEM stage (master) and the memory (slave).
interface mem_access_if #(parameter int DATA_WIDTH = 32);

  logic                                     req;
  logic                                     we;
  logic [mem_access_pkg::DMEM_BE_WIDTH-1:0] be;
  logic [DATA_WIDTH-1:0]                    addr;
  logic [DATA_WIDTH-1:0]                    wdata;
  logic                                     gnt;
  logic [DATA_WIDTH-1:0]                    rdata;
  logic                                     rvalid;

  modport master (output req, we, be, addr, wdata, input gnt, rdata, rvalid);
  modport slave  (input req, we, be, addr, wdata, output gnt, rdata, rvalid);

endinterface

// File: rtl/mem_access_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load extraction/extension.
module lsu_align
  import mem_access_pkg::*;
(
  input  logic [1:0]               addr,
  input  logic [2:0]               funct3,
  input  logic [31:0]              sdata,
  input  logic [31:0]              rword,
  output logic [DMEM_BE_WIDTH-1:0] be,
  output logic [31:0]              wdata,
  output logic [31:0]              ldata,
  output logic                     err
);

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  always_comb begin
    err    = access_err(funct3, addr);
    byte_l = rword[{addr, 3'b000} +: 8];
    half_l = addr[1] ? rword[31:16] : rword[15:0];
    be     = '0;
    wdata  = '0;
    ldata  = '0;
    // funct3[2] marks the unsigned load variants
    case (funct3)
      MEM_B, MEM_BU: begin
        be    = 4'b0001 << addr;
        wdata = {4{sdata[7:0]}};
        ldata = {{24{byte_l[7] & ~funct3[2]}}, byte_l};
      end
      MEM_H, MEM_HU: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sdata[15:0]}};
        ldata = {{16{half_l[15] & ~funct3[2]}}, half_l};
      end
      MEM_W: begin
        be    = 4'b1111;
        wdata = sdata;
        ldata = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rv32i MEM stage: EX/MEM register, data-memory handshake FSM, load alignment and MEM/WB register.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid,
  input  logic [DATA_WIDTH-1:0]  ex_alu_result,
  input  logic [DATA_WIDTH-1:0]  ex_mem_wdata,
  input  logic [RADDR_WIDTH-1:0] ex_reg_rd,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic                   ex_mem_write,
  input  logic [2:0]             ex_funct3,
  input  logic                   ex_mem_to_reg,
  output logic                   stall,
  output logic                   exmem_reg_write,
  output logic [RADDR_WIDTH-1:0] exmem_reg_rd,
  output logic [DATA_WIDTH-1:0]  exmem_reg_wdata,
  mem_access_if.master           dmem,
  output logic                   memwb_reg_write,
  output logic [RADDR_WIDTH-1:0] memwb_reg_rd,
  output logic [DATA_WIDTH-1:0]  wb_reg_wdata,
  output logic                   misalign_err
);

  mem_state_t             state;
  logic                   req_q;

  logic                   em_valid, em_reg_write, em_read, em_write, em_to_reg;
  logic [DATA_WIDTH-1:0]  em_alu, em_wdata;
  logic [RADDR_WIDTH-1:0] em_rd;
  logic [2:0]             em_funct3;

  logic [DMEM_BE_WIDTH-1:0] lsu_be;
  logic [DATA_WIDTH-1:0]    lsu_wdata, lsu_ldata;
  logic                     lsu_err, em_bad, ex_go;

  lsu_align u_align (
    .addr   (em_alu[1:0]),
    .funct3 (em_funct3),
    .sdata  (em_wdata),
    .rword  (dmem.rdata),
    .be     (lsu_be),
    .wdata  (lsu_wdata),
    .ldata  (lsu_ldata),
    .err    (lsu_err)
  );

  assign em_bad = em_valid & (em_read | em_write) & lsu_err;
  assign ex_go  = ex_valid & (ex_mem_read | ex_mem_write) & ~access_err(ex_funct3, ex_alu_result[1:0]);
  assign stall  = ((state == S_REQ)  & ~(dmem.gnt & em_write)) |
                  ((state == S_RESP) & ~dmem.rvalid);

  // A completing op frees the stage on the same edge, so a new op can go straight to S_REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      req_q <= 1'b0;
    end else if (!stall) begin
      state <= ex_go ? S_REQ : S_IDLE;
      req_q <= ex_go;
    end else if (state == S_REQ && dmem.gnt) begin
      state <= S_RESP;
      req_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      em_valid     <= 1'b0;
      em_alu       <= '0;
      em_wdata     <= '0;
      em_rd        <= '0;
      em_reg_write <= 1'b0;
      em_read      <= 1'b0;
      em_write     <= 1'b0;
      em_funct3    <= '0;
      em_to_reg    <= 1'b0;
    end else if (!stall) begin
      em_valid     <= ex_valid;
      em_alu       <= ex_alu_result;
      em_wdata     <= ex_mem_wdata;
      em_rd        <= ex_reg_rd;
      em_reg_write <= ex_reg_write;
      em_read      <= ex_mem_read;
      em_write     <= ex_mem_write;
      em_funct3    <= ex_funct3;
      em_to_reg    <= ex_mem_to_reg;
    end
  end

  // Held rather than bubbled during stall so EX forwarding from WB stays valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memwb_reg_write <= 1'b0;
      memwb_reg_rd    <= '0;
      wb_reg_wdata    <= '0;
    end else if (!stall) begin
      memwb_reg_write <= em_valid & em_reg_write & ~em_bad;
      memwb_reg_rd    <= em_rd;
      wb_reg_wdata    <= em_to_reg ? lsu_ldata : em_alu;
    end
  end

  assign dmem.req        = req_q;
  assign dmem.we         = req_q & em_write;
  assign dmem.be         = req_q ? lsu_be : '0;
  assign dmem.addr       = req_q ? {em_alu[DATA_WIDTH-1:2], 2'b00} : '0;
  assign dmem.wdata      = (req_q & em_write) ? lsu_wdata : '0;

  assign exmem_reg_write = em_valid & em_reg_write;
  assign exmem_reg_rd    = em_rd;
  assign exmem_reg_wdata = em_alu;
  assign misalign_err    = em_bad;

endmodule
